// File: rtl/pci_pkg.sv
// Shared definitions for the PCI memory target: bus command codes, FSM state type
// and the width helper used to size the word index.
package pci_pkg;

    localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
    localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLAIM,
        S_WAIT,
        S_DATA,
        S_DISC,
        S_TAR
    } pci_state_e;

    function automatic int pci_clog2(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/pci_mem_target_if.sv
// Split-pin PCI target bus bundle (in/out/output-enable form for a tri-state wrapper)
// plus the target FSM state for observation.
interface pci_mem_target_if #(
    parameter int DATA_W = 32
);
    import pci_pkg::*;

    localparam int BE_W = DATA_W / 8;

    // A data phase completes on the rising edge where IRDY# (initiator valid) and
    // TRDY# (target ready) are both low; either side may hold its signal high to stall.
    logic [DATA_W-1:0] ad_in;
    logic [DATA_W-1:0] ad_out;
    logic              ad_oe;
    logic [BE_W-1:0]   cbe_n;
    logic              frame_n;
    logic              irdy_n;
    logic              devsel_n;
    logic              trdy_n;
    logic              stop_n;
    logic              ctl_oe;
    logic              busy;
    pci_state_e        dbg_state;

    modport slave (
        input  ad_in, cbe_n, frame_n, irdy_n,
        output ad_out, ad_oe, devsel_n, trdy_n, stop_n, ctl_oe, busy, dbg_state
    );

    modport master (
        output ad_in, cbe_n, frame_n, irdy_n,
        input  ad_out, ad_oe, devsel_n, trdy_n, stop_n, ctl_oe, busy, dbg_state
    );

endinterface

// File: rtl/pci_be_mem.sv
// Word-addressed memory with per-byte write enables; the read address is registered,
// so the caller presents the next index to get that word one cycle later.
module pci_be_mem
    import pci_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic                         clk,
    input  logic                         we_i,
    input  logic [pci_clog2(DEPTH)-1:0]  waddr_i,
    input  logic [DATA_W-1:0]            wdata_i,
    input  logic [DATA_W/8-1:0]          be_i,
    input  logic [pci_clog2(DEPTH)-1:0]  raddr_i,
    output logic [DATA_W-1:0]            rdata_o
);
    localparam int IDX_W = pci_clog2(DEPTH);
    localparam int BE_W  = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0]  raddr_q;

    always_ff @(posedge clk) begin
        raddr_q <= raddr_i;
        if (we_i) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    assign rdata_o = mem_q[raddr_q];

endmodule

// File: rtl/pci_mem_target.sv
// PCI memory target with single-BAR decode, burst read/write and initial wait states.
// Define PCI_TGT_DISCONNECT_EN to disconnect at the window end instead of wrapping.
module pci_mem_target
    import pci_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                DEPTH       = 32,
    parameter logic [DATA_W-1:0] BAR         = DATA_W'(32'h0000_0100),
    parameter int                WAIT_STATES = 0
) (
    input logic             clk,
    input logic             rst,
    pci_mem_target_if.slave bus
);
    localparam int BE_W     = DATA_W / 8;
    localparam int IDX_W    = pci_clog2(DEPTH);
    localparam int OFF_W    = pci_clog2(BE_W);
    localparam int WIN_LSB  = OFF_W + IDX_W;
    localparam int FIRST_WR = WAIT_STATES;
    // Reads need at least one cycle for the AD bus turnaround.
    localparam int FIRST_RD = (WAIT_STATES < 1) ? 1 : WAIT_STATES;

    pci_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [2:0]       wcnt_q, wcnt_d;
    logic             rd_q, rd_d;
    logic             frame_q;

    logic              addr_phase, hit, is_rd, is_wr;
    logic              mem_we;
    logic              devsel_n, trdy_n, stop_n, ctl_oe, ad_oe;
    logic [DATA_W-1:0] rdata;

    assign addr_phase = !bus.frame_n && frame_q;
    assign hit        = bus.ad_in[DATA_W-1:WIN_LSB] == BAR[DATA_W-1:WIN_LSB];
    assign is_rd      = bus.cbe_n[3:0] == CMD_MEM_READ;
    assign is_wr      = bus.cbe_n[3:0] == CMD_MEM_WRITE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wcnt_q  <= '0;
            rd_q    <= 1'b0;
            frame_q <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            rd_q    <= rd_d;
            frame_q <= bus.frame_n;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wcnt_d   = wcnt_q;
        rd_d     = rd_q;
        mem_we   = 1'b0;
        devsel_n = 1'b1;
        trdy_n   = 1'b1;
        stop_n   = 1'b1;
        ctl_oe   = 1'b1;
        ad_oe    = 1'b0;
        case (state_q)
            S_IDLE: begin
                ctl_oe = 1'b0;
                if (addr_phase && hit && (is_rd || is_wr)) begin
                    idx_d = bus.ad_in[OFF_W +: IDX_W];
                    rd_d  = is_rd;
                    if (is_rd) begin
                        state_d = S_CLAIM;
                        wcnt_d  = 3'(FIRST_RD - 1);
                    end else if (FIRST_WR == 0) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_CLAIM;
                        wcnt_d  = 3'(FIRST_WR - 1);
                    end
                end
            end
            S_CLAIM, S_WAIT: begin
                devsel_n = 1'b0;
                ad_oe    = rd_q && (state_q == S_WAIT);
                if (bus.frame_n && bus.irdy_n) begin
                    state_d = S_TAR;
                end else if (wcnt_q == '0) begin
                    state_d = S_DATA;
                end else begin
                    wcnt_d  = wcnt_q - 3'd1;
                    state_d = S_WAIT;
                end
            end
            S_DATA: begin
                devsel_n = 1'b0;
                trdy_n   = 1'b0;
                ad_oe    = rd_q;
                if (!bus.irdy_n) begin
                    mem_we = !rd_q;
                    idx_d  = idx_q + 1'b1;
                    if (bus.frame_n) state_d = S_TAR;
`ifdef PCI_TGT_DISCONNECT_EN
                    else if (idx_q == IDX_W'(DEPTH - 1)) state_d = S_DISC;
`endif
                end else if (bus.frame_n) begin
                    state_d = S_TAR;
                end
            end
            S_DISC: begin
                devsel_n = 1'b0;
`ifdef PCI_TGT_DISCONNECT_EN
                stop_n   = 1'b0;
`endif
                if (bus.frame_n) state_d = S_TAR;
            end
            S_TAR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    pci_be_mem #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk    (clk),
        .we_i   (mem_we && !rst),
        .waddr_i(idx_q),
        .wdata_i(bus.ad_in),
        .be_i   (~bus.cbe_n),
        .raddr_i(idx_d),
        .rdata_o(rdata)
    );

    assign bus.ad_out    = ad_oe ? rdata : '0;
    assign bus.ad_oe     = ad_oe;
    assign bus.devsel_n  = devsel_n;
    assign bus.trdy_n    = trdy_n;
    assign bus.stop_n    = stop_n;
    assign bus.ctl_oe    = ctl_oe;
    assign bus.busy      = state_q != S_IDLE;
    assign bus.dbg_state = state_q;

endmodule
